axis_data_to_axis_string: RTL and testbench

AXIS_DATA_TO_AXIS_STRING -- requirements
Module: axis_data_to_axis_string

---
 rtl/axis_data_to_axis_string_pkg.sv | 23 ++
 rtl/hex_nibble_to_ascii.sv | 16 +
 rtl/axis_data_to_axis_string.sv | 151 +++++++++++++++
 tb/tb_axis_data_to_axis_string.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_data_to_axis_string_pkg.sv
// Shared constants and helpers for the binary-to-ASCII AXI-Stream string encoder.
package axis_data_to_axis_string_pkg;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_UC_A = 8'h41;
  localparam logic [7:0] ASCII_LC_A = 8'h61;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_e;

  function automatic int str_len(input int prefix_len, input int sbus_width,
                                 input int dest_width, input int user_width);
    return 3 * prefix_len + 2 * sbus_width + (dest_width + 3) / 4 + (user_width + 3) / 4 + 3;
  endfunction

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib, input logic lower);
    if (nib < 4'd10) return ASCII_0 + {4'h0, nib};
    return (lower ? ASCII_LC_A : ASCII_UC_A) + {4'h0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational nibble-to-hex-character converter.
// AXIS_DATA_TO_AXIS_STRING_LOWER_HEX_EN selects lowercase a-f (uppercase otherwise).
module hex_nibble_to_ascii
  import axis_data_to_axis_string_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

`ifdef AXIS_DATA_TO_AXIS_STRING_LOWER_HEX_EN
  assign ascii_o = nibble_to_ascii(nibble_i, 1'b1);
`else
  assign ascii_o = nibble_to_ascii(nibble_i, 1'b0);
`endif

endmodule

// File: rtl/axis_data_to_axis_string.sv
// Converts each input AXIS beat into an ASCII string "<P>data;<P>dest;<P>user<TERM>".
// Hex case follows AXIS_DATA_TO_AXIS_STRING_LOWER_HEX_EN (see hex_nibble_to_ascii).
module axis_data_to_axis_string
  import axis_data_to_axis_string_pkg::*;
#(
  parameter logic [7:0]              DELIMITER   = ";",
  parameter logic [7:0]              TERMINATION = "\n",
  parameter int                      SBUS_WIDTH  = 1,
  parameter int                      USER_WIDTH  = 4,
  parameter int                      DEST_WIDTH  = 4,
  parameter int                      PREFIX_LEN  = 1,
  parameter logic [PREFIX_LEN*8-1:0] DATA_PREFIX = "#",
  parameter logic [PREFIX_LEN*8-1:0] DEST_PREFIX = "&",
  parameter logic [PREFIX_LEN*8-1:0] USER_PREFIX = "*"
) (
  input  logic                    aclk,
  input  logic                    arst,
  input  logic [SBUS_WIDTH*8-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  input  logic [DEST_WIDTH-1:0]   s_axis_tdest,
  output logic [7:0]              m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready
);

  localparam int L      = str_len(PREFIX_LEN, SBUS_WIDTH, DEST_WIDTH, USER_WIDTH);
  localparam int DD     = 2 * SBUS_WIDTH;
  localparam int ND     = (DEST_WIDTH + 3) / 4;
  localparam int NU     = (USER_WIDTH + 3) / 4;
  localparam int O_DDIG = PREFIX_LEN;
  localparam int O_DDEL = O_DDIG + DD;
  localparam int O_EPRE = O_DDEL + 1;
  localparam int O_EDIG = O_EPRE + PREFIX_LEN;
  localparam int O_EDEL = O_EDIG + ND;
  localparam int O_UPRE = O_EDEL + 1;
  localparam int O_UDIG = O_UPRE + PREFIX_LEN;
  localparam int IDX_W  = $clog2(L);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(L - 1);

  state_e                  state_q;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [SBUS_WIDTH*8-1:0] data_q;
  logic [DEST_WIDTH-1:0]   dest_q;
  logic [USER_WIDTH-1:0]   user_q;
  logic [7:0]              tdata_q, char_d, lit, hex_char;
  logic                    tvalid_q, tready_q, is_hex;
  logic [3:0]              nib;
  logic [ND*4-1:0]         dest_ext;
  logic [NU*4-1:0]         user_ext;
  int                      pos;

  assign idx_d = idx_q + IDX_W'(1);

  always_comb begin
    dest_ext = '0;
    dest_ext[DEST_WIDTH-1:0] = dest_q;
    user_ext = '0;
    user_ext[USER_WIDTH-1:0] = user_q;
  end

  // Character mux: picks the character at idx_d so it can be registered on acceptance.
  always_comb begin
    pos    = int'(idx_d);
    is_hex = 1'b0;
    nib    = 4'h0;
    lit    = TERMINATION;
    for (int k = 0; k < PREFIX_LEN; k++) begin
      if (pos == k)          lit = DATA_PREFIX[(PREFIX_LEN-1-k)*8 +: 8];
      if (pos == O_EPRE + k) lit = DEST_PREFIX[(PREFIX_LEN-1-k)*8 +: 8];
      if (pos == O_UPRE + k) lit = USER_PREFIX[(PREFIX_LEN-1-k)*8 +: 8];
    end
    if (pos == O_DDEL || pos == O_EDEL) lit = DELIMITER;
    for (int j = 0; j < DD; j++) begin
      if (pos == O_DDIG + j) begin
        is_hex = 1'b1;
        nib    = data_q[(DD-1-j)*4 +: 4];
      end
    end
    for (int j = 0; j < ND; j++) begin
      if (pos == O_EDIG + j) begin
        is_hex = 1'b1;
        nib    = dest_ext[(ND-1-j)*4 +: 4];
      end
    end
    for (int j = 0; j < NU; j++) begin
      if (pos == O_UDIG + j) begin
        is_hex = 1'b1;
        nib    = user_ext[(NU-1-j)*4 +: 4];
      end
    end
  end

  hex_nibble_to_ascii u_hex (
    .nibble_i (nib),
    .ascii_o  (hex_char)
  );

  assign char_d = is_hex ? hex_char : lit;

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      data_q   <= '0;
      dest_q   <= '0;
      user_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tready_q <= 1'b1;
          if (s_axis_tvalid && tready_q) begin
            data_q   <= s_axis_tdata;
            dest_q   <= s_axis_tdest;
            user_q   <= s_axis_tuser;
            idx_q    <= '0;
            // The first character is always the data prefix, independent of the payload.
            tdata_q  <= DATA_PREFIX[PREFIX_LEN*8-1 -: 8];
            tvalid_q <= 1'b1;
            tready_q <= 1'b0;
            state_q  <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (m_axis_tready) begin
            if (idx_q == LAST_IDX) begin
              state_q  <= ST_IDLE;
              idx_q    <= '0;
              tdata_q  <= '0;
              tvalid_q <= 1'b0;
              tready_q <= 1'b1;
            end else begin
              idx_q   <= idx_d;
              tdata_q <= char_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_axis_data_to_axis_string.sv
// Bench for axis_data_to_axis_string: string-level reference model plus literal expectations.
module tb_axis_data_to_axis_string;

  logic       aclk = 1'b0;
  logic       arst = 1'b1;
  logic [7:0] s_tdata = '0;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic [3:0] s_tuser = '0;
  logic [3:0] s_tdest = '0;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready = 1'b1;

  axis_data_to_axis_string dut (
    .aclk          (aclk),
    .arst          (arst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tuser  (s_tuser),
    .s_axis_tdest  (s_tdest),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready)
  );

  always #5 aclk = ~aclk;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] expq[$];
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         cap_q[$];
  bit         stalled = 1'b0;
  bit         first_due = 1'b0;
  logic [7:0] held = '0;
  bit         bp_en = 1'b0;

  always @(posedge aclk) cyc <= cyc + 1;

  always @(posedge aclk) begin
    if (bp_en) begin
      #1 m_tready = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk_str(input string name, input string exp);
    string g = "";
    foreach (got_q[i]) g = $sformatf("%s%c", g, got_q[i]);
    checks++;
    if (g != exp) begin
      failures++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, g, exp);
    end
  endtask

  // Expected string straight from the format rules: prefix, hex, delimiter ... terminator.
  function automatic string model_str(input logic [7:0] d, input logic [3:0] e, input logic [3:0] u);
    string s;
    s = $sformatf("#%02h;&%01h;*%01h\n", d, e, u);
`ifndef AXIS_DATA_TO_AXIS_STRING_LOWER_HEX_EN
    s = s.toupper();
`endif
    return s;
  endfunction

  function automatic string cs(input string s);
`ifdef AXIS_DATA_TO_AXIS_STRING_LOWER_HEX_EN
    return s.tolower();
`else
    return s;
`endif
  endfunction

  always @(negedge aclk) begin
    if (arst) begin
      expq.delete();
      stalled   = 1'b0;
      first_due = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid_held", 32'(m_tvalid), 32'd1);
        chk("stall_data_held", 32'(m_tdata), 32'(held));
      end
      if (first_due) begin
        chk("first_char_latency", 32'(m_tvalid), 32'd1);
        first_due = 1'b0;
      end
      if (m_tvalid) chk("s_tready_low_in_string", 32'(s_tready), 32'd0);
      if (m_tvalid && m_tready) begin
        if (expq.size() == 0) begin
          chk("unexpected_char", 32'(m_tdata), 32'hFFFF_FFFF);
        end else begin
          chk("char_vs_model", 32'(m_tdata), 32'(expq.pop_front()));
        end
        got_q.push_back(m_tdata);
        got_cyc.push_back(cyc);
      end
      if (s_tvalid && s_tready) begin
        string s;
        s = model_str(s_tdata, s_tdest, s_tuser);
        for (int i = 0; i < s.len(); i++) expq.push_back(8'(s[i]));
        first_due = 1'b1;
        cap_q.push_back(cyc);
      end
      stalled = m_tvalid && !m_tready;
      held    = m_tdata;
    end
  end

  task automatic clear_log();
    got_q.delete();
    got_cyc.delete();
    cap_q.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] e, input logic [3:0] u);
    int n;
    n = 0;
    s_tdata  = d;
    s_tdest  = e;
    s_tuser  = u;
    s_tvalid = 1'b1;
    do begin
      @(negedge aclk);
      n++;
    end while (!s_tready && n < 200);
    chk("send_accepted", 32'(s_tready), 32'd1);
    @(posedge aclk);
    #1 s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || m_tvalid) && n < 4000) begin
      @(posedge aclk);
      #1;
      n++;
    end
    chk("drain_model_empty", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // Reset state
    #12;
    chk("reset_tready", 32'(s_tready), 32'd0);
    chk("reset_tvalid", 32'(m_tvalid), 32'd0);
    chk("reset_tdata", 32'(m_tdata), 32'd0);
    @(posedge aclk);
    #1 arst = 1'b0;
    @(negedge aclk);
    chk("tready_before_first_edge", 32'(s_tready), 32'd0);
    @(posedge aclk);
    #1 chk("tready_after_first_edge", 32'(s_tready), 32'd1);

    // Basic string, latency and back-to-back timing
    clear_log();
    send(8'hA5, 4'h3, 4'hC);
    drain();
    chk_str("str_a5", cs("#A5;&3;*C\n"));
    chk("str_a5_len", 32'(got_q.size()), 32'd10);
    if (got_q.size() == 10 && cap_q.size() == 1) begin
      chk("first_char_one_cycle", 32'(got_cyc[0] - cap_q[0]), 32'd1);
      chk("ten_consecutive_cycles", 32'(got_cyc[9] - got_cyc[0]), 32'd9);
    end

    // All-zero then all-ones, offered back to back
    clear_log();
    send(8'h00, 4'h0, 4'h0);
    send(8'hFF, 4'hF, 4'hF);
    drain();
    chk_str("str_00_ff", cs("#00;&0;*0\n#FF;&F;*F\n"));
    if (got_cyc.size() == 20 && cap_q.size() == 2)
      chk("next_capture_after_terminator", 32'(cap_q[1] > got_cyc[9]), 32'd1);

    // Random backpressure over 256 beats
    clear_log();
    bp_en = 1'b1;
    for (int i = 0; i < 256; i++) send(8'(i), 4'($urandom), 4'($urandom));
    bp_en = 1'b0;
    @(posedge aclk);
    #2 m_tready = 1'b1;
    drain();
    chk("bp_total_chars", 32'(got_q.size()), 32'd2560);

    // Reset in the middle of a string
    clear_log();
    s_tdata  = 8'h3C;
    s_tdest  = 4'h5;
    s_tuser  = 4'h9;
    s_tvalid = 1'b1;
    n = 0;
    while (got_q.size() < 4 && n < 100) begin
      @(posedge aclk);
      #1 s_tvalid = 1'b0;
      n++;
    end
    chk("four_chars_before_reset", 32'(got_q.size()), 32'd4);
    #2 arst = 1'b1;
    #1;
    chk("midreset_tvalid", 32'(m_tvalid), 32'd0);
    chk("midreset_tdata", 32'(m_tdata), 32'd0);
    chk("midreset_tready", 32'(s_tready), 32'd0);
    repeat (2) @(posedge aclk);
    #1 arst = 1'b0;
    repeat (4) begin
      @(posedge aclk);
      #1 chk("no_tail_after_reset", 32'(m_tvalid), 32'd0);
    end
    clear_log();
    send(8'h5A, 4'h6, 4'hB);
    drain();
    chk_str("str_after_reset", cs("#5A;&6;*B\n"));

    // Letters-only payload, case selected by build option
    clear_log();
    send(8'hBE, 4'hA, 4'hD);
    drain();
`ifdef AXIS_DATA_TO_AXIS_STRING_LOWER_HEX_EN
    chk_str("str_be", "#be;&a;*d\n");
`else
    chk_str("str_be", "#BE;&A;*D\n");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
